// File: rtl/a2d_pkg.sv
// a2d_pkg: command frame layout and state type shared by the A2D SPI blocks
package a2d_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int FRAME_BITS = 16;
  localparam int CH_MSB = 13;
  localparam int CH_LSB = 11;
  localparam int RES_W = 12;
endpackage

// File: rtl/a2d_spi_resp_sync_edge.sv
// spi_sync_edge: multi-stage synchronizer with rise/fall detection on the synchronized level
module spi_sync_edge #(
  parameter int   STG = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STG-1:0] sync_q;
  logic prev_q;
  // shift the async input through the synchronizer and keep one delayed copy for edges
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= {STG{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= STG'({sync_q, d_i});
      prev_q <= sync_q[STG-1];
    end
  assign sync_o = sync_q[STG-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;
endmodule

// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI responder emulating an 8-channel 12-bit A2D with one-frame response pipelining
module a2d_spi_resp #(
  parameter int N_CH = 8,
  parameter int RES_W = 12,
  parameter int SYNC_STG = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic [N_CH*RES_W-1:0] ana_vals,
  output logic                  MISO,
  output logic [2:0]            cmd_chnnl,
  output logic                  frame_done,
  output logic                  frm_err
);
  import a2d_pkg::*;
  logic ss_sync, ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_sync;
  state_t state_q, state_d;
  logic [FRAME_BITS-1:0] rx_shft_q, rx_shft_d, tx_shft_q, tx_shft_d, resp_q, resp_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] chnnl_q, chnnl_d;
  logic done_q, done_d, err_q, err_d;
  logic [FRAME_BITS-1:0] rx_n;
  logic [4:0] cnt_n;
  logic [2:0] ch_n;

  spi_sync_edge #(.STG(SYNC_STG), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst_n(rst_n), .d_i(SS_n), .sync_o(ss_sync), .rise_o(ss_rise), .fall_o(ss_fall));
  spi_sync_edge #(.STG(SYNC_STG), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(SCLK), .sync_o(), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync_edge #(.STG(SYNC_STG), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(MOSI), .sync_o(mosi_sync), .rise_o(), .fall_o());

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      rx_shft_q <= '0;
      tx_shft_q <= '0;
      resp_q    <= '0;
      bit_cnt_q <= '0;
      chnnl_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_shft_q <= rx_shft_d;
      tx_shft_q <= tx_shft_d;
      resp_q    <= resp_d;
      bit_cnt_q <= bit_cnt_d;
      chnnl_q   <= chnnl_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end

  // next state: the SCLK rise is folded in before the frame-end check so a coincident ss_rise sees the new count
  always_comb begin
    state_d   = state_q;
    rx_shft_d = rx_shft_q;
    tx_shft_d = tx_shft_q;
    resp_d    = resp_q;
    bit_cnt_d = bit_cnt_q;
    chnnl_d   = chnnl_q;
    err_d     = err_q;
    done_d    = 1'b0;
    rx_n      = sclk_rise ? {rx_shft_q[FRAME_BITS-2:0], mosi_sync} : rx_shft_q;
    cnt_n     = (sclk_rise && bit_cnt_q != 5'd31) ? bit_cnt_q + 5'd1 : bit_cnt_q;
    ch_n      = rx_n[CH_MSB:CH_LSB];
    if (state_q == IDLE) begin
      if (ss_fall) begin
        tx_shft_d = resp_q;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
    end else begin
      rx_shft_d = rx_n;
      bit_cnt_d = cnt_n;
      if (sclk_fall && bit_cnt_q != 5'd0)
        tx_shft_d = {tx_shft_q[FRAME_BITS-2:0], 1'b0};
      if (ss_rise) begin
        state_d = IDLE;
        if (cnt_n == 5'(FRAME_BITS)) begin
          chnnl_d = ch_n;
          resp_d  = {{(FRAME_BITS-RES_W){1'b0}}, ana_vals[ch_n*RES_W +: RES_W]};
          done_d  = 1'b1;
        end else
          err_d = 1'b1;
      end
    end
  end

  // outputs: MISO presents the transmit MSB only while selected
  always_comb begin
    MISO       = ss_sync ? 1'b0 : tx_shft_q[FRAME_BITS-1];
    cmd_chnnl  = chnnl_q;
    frame_done = done_q;
    frm_err    = err_q;
  end
endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb_a2d_spi_resp: scoreboard bench driving SPI frames into the A2D responder
module tb_a2d_spi_resp;
  logic clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
  logic [95:0] ana_vals;
  logic MISO, frame_done, frm_err;
  logic [2:0] cmd_chnnl;
  int checks = 0, failures = 0, fd_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_resp = 16'h0;
  logic [2:0] model_ch = 3'd0;

  a2d_spi_resp dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .ana_vals(ana_vals),
    .MISO(MISO), .cmd_chnnl(cmd_chnnl), .frame_done(frame_done), .frm_err(frm_err));

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] cmd, input int nbits, output logic [15:0] rx);
    rx = 16'h0;
    SS_n = 1'b0;
    wclk(8);
    for (int i = 0; i < nbits; i++) begin
      MOSI = cmd[15-i];
      wclk(8);
      rx = {rx[14:0], MISO};
      SCLK = 1'b1;
      wclk(8);
      SCLK = 1'b0;
    end
    wclk(8);
    SS_n = 1'b1;
    wclk(8);
  endtask

  task automatic full(input logic [2:0] ch, input logic [1:0] hi, input logic [10:0] lo);
    logic [15:0] rx, exp;
    int fd0;
    exp_q.push_back(model_resp);
    fd0 = fd_cnt;
    frame({hi, ch, lo}, 16, rx);
    exp = exp_q.pop_front();
    check("resp", {16'h0, rx}, {16'h0, exp});
    check("frame_done_cnt", fd_cnt - fd0, 1);
    check("cmd_chnnl", {29'h0, cmd_chnnl}, {29'h0, ch});
    check("miso_idle", {31'h0, MISO}, 0);
    model_resp = {4'h0, ana_vals[ch*12 +: 12]};
    model_ch = ch;
  endtask

  task automatic set_pattern();
    for (int k = 0; k < 8; k++) ana_vals[k*12 +: 12] = 12'(k * 256 + 15);
  endtask

  initial begin
    logic [15:0] rx, pre;
    int fd0;
    set_pattern();
    wclk(3);
    check("rst_miso", {31'h0, MISO}, 0);
    check("rst_chnnl", {29'h0, cmd_chnnl}, 0);
    check("rst_done", {31'h0, frame_done}, 0);
    check("rst_err", {31'h0, frm_err}, 0);
    rst_n = 1'b1;
    wclk(3);
    full(3'd0, 2'b00, 11'h000);
    ana_vals[3*12 +: 12] = 12'hA5C;
    full(3'd3, 2'b00, 11'h000);
    full(3'd0, 2'b11, 11'h7FF);
    check("ch3_resp_model", {16'h0, model_resp}, 32'h0000_000F);
    set_pattern();
    for (int k = 0; k < 8; k++) full(3'(k), 2'(k), 11'(k * 93));
    full(3'd0, 2'b01, 11'h2AA);
    check("sweep_last_model", {16'h0, model_resp}, 32'h0000_000F);
    full(3'd6, 2'b00, 11'h000);
    pre = model_resp;
    fd0 = fd_cnt;
    frame({2'b00, 3'd2, 11'h0}, 9, rx);
    check("abort_done", fd_cnt - fd0, 0);
    check("abort_err", {31'h0, frm_err}, 1);
    check("abort_chnnl", {29'h0, cmd_chnnl}, {29'h0, model_ch});
    full(3'd5, 2'b10, 11'h155);
    check("post_abort_pre", {16'h0, pre}, 32'h0000_060F);
    check("err_sticky", {31'h0, frm_err}, 1);
    SS_n = 1'b0;
    MOSI = 1'b1;
    wclk(8);
    for (int i = 0; i < 6; i++) begin
      SCLK = 1'b1;
      wclk(8);
      SCLK = 1'b0;
      wclk(8);
    end
    SCLK = 1'b1;
    wclk(2);
    rst_n = 1'b0;
    wclk(1);
    check("midrst_miso", {31'h0, MISO}, 0);
    check("midrst_chnnl", {29'h0, cmd_chnnl}, 0);
    check("midrst_err", {31'h0, frm_err}, 0);
    SS_n = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    wclk(4);
    rst_n = 1'b1;
    wclk(4);
    model_resp = 16'h0;
    model_ch = 3'd0;
    full(3'd4, 2'b00, 11'h000);
    full(3'd1, 2'b00, 11'h000);
    check("final_err", {31'h0, frm_err}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
